aq_rtu_gpr_wb_ctrl: RTL and testbench

GPR writeback controller in the RTU: the transmit end of the two-port GPR writeback interface consumed by the IDU physical-register file.
- Collects results from three producers: ALU (no backpressure), LSU and MDU (valid/ready).
- Arbitrates them onto registered writeback ports wb0/wb1.
- Guarantees the two ports never target the same register in one cycle. The receiver resolves a simultaneous double write to the same register as "hold old value", so this is a hard invariant.

---
 rtl/aq_rtu_gpr_wb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_aq_rtu_gpr_wb_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_rtu_gpr_wb_ctrl.sv
// GPR writeback controller: merges ALU, LSU and MDU results onto two registered
// writeback ports that never target the same register in the same cycle.
module aq_rtu_gpr_wb_ctrl #(
    parameter int unsigned PREG_W       = 6,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              rtu_yy_xx_flush,
    input  logic              alu_wb_vld,
    input  logic [PREG_W-1:0] alu_wb_preg,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              lsu_wb_vld,
    input  logic [PREG_W-1:0] lsu_wb_preg,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic              lsu_wb_rdy,
    input  logic              mdu_wb_vld,
    input  logic [PREG_W-1:0] mdu_wb_preg,
    input  logic [DATA_W-1:0] mdu_wb_data,
    output logic              mdu_wb_rdy,
    output logic              rtu_idu_wb0_vld,
    output logic [PREG_W-1:0] rtu_idu_wb0_preg,
    output logic [DATA_W-1:0] rtu_idu_wb0_data,
    output logic              rtu_idu_wb1_vld,
    output logic [PREG_W-1:0] rtu_idu_wb1_preg,
    output logic [DATA_W-1:0] rtu_idu_wb1_data
);

    localparam int unsigned NCAND          = 3;
    localparam logic [3:0]  LP_STARVE_LIM  = 4'(STARVE_LIMIT);
    localparam logic [3:0]  LP_STARVE_MAX  = 4'hF;

    logic              r_lsu_vld;
    logic [PREG_W-1:0] r_lsu_preg;
    logic [DATA_W-1:0] r_lsu_data;
    logic              r_mdu_vld;
    logic [PREG_W-1:0] r_mdu_preg;
    logic [DATA_W-1:0] r_mdu_data;
    logic [3:0]        r_starve;

    logic              r_wb0_vld;
    logic [PREG_W-1:0] r_wb0_preg;
    logic [DATA_W-1:0] r_wb0_data;
    logic              r_wb1_vld;
    logic [PREG_W-1:0] r_wb1_preg;
    logic [DATA_W-1:0] r_wb1_data;

    logic              w_promote;
    logic [NCAND-1:0]  w_cand_vld;
    logic [PREG_W-1:0] w_cand_preg [NCAND];
    logic [DATA_W-1:0] w_cand_data [NCAND];
    logic [NCAND-1:0]  w_gnt;

    logic              w_p0_vld;
    logic [PREG_W-1:0] w_p0_preg;
    logic [DATA_W-1:0] w_p0_data;
    logic              w_p1_vld;
    logic [PREG_W-1:0] w_p1_preg;
    logic [DATA_W-1:0] w_p1_data;

    logic              w_lsu_gnt;
    logic              w_mdu_gnt;
    logic              w_lsu_acc;
    logic              w_mdu_acc;

    assign w_promote = (r_starve >= LP_STARVE_LIM);

    // Slot 0 is always the ALU; slots 1/2 swap when the MDU is promoted.
    always_comb begin
        w_cand_vld     = '0;
        w_cand_vld[0]  = alu_wb_vld & ~rtu_yy_xx_flush;
        w_cand_preg[0] = alu_wb_preg;
        w_cand_data[0] = alu_wb_data;
        if (w_promote) begin
            w_cand_vld[1]  = r_mdu_vld & ~rtu_yy_xx_flush;
            w_cand_preg[1] = r_mdu_preg;
            w_cand_data[1] = r_mdu_data;
            w_cand_vld[2]  = r_lsu_vld & ~rtu_yy_xx_flush;
            w_cand_preg[2] = r_lsu_preg;
            w_cand_data[2] = r_lsu_data;
        end else begin
            w_cand_vld[1]  = r_lsu_vld & ~rtu_yy_xx_flush;
            w_cand_preg[1] = r_lsu_preg;
            w_cand_data[1] = r_lsu_data;
            w_cand_vld[2]  = r_mdu_vld & ~rtu_yy_xx_flush;
            w_cand_preg[2] = r_mdu_preg;
            w_cand_data[2] = r_mdu_data;
        end
    end

    // Zero-index writes are granted without occupying a port.
    always_comb begin
        w_gnt     = '0;
        w_p0_vld  = 1'b0;
        w_p0_preg = '0;
        w_p0_data = '0;
        w_p1_vld  = 1'b0;
        w_p1_preg = '0;
        w_p1_data = '0;
        for (int i = 0; i < int'(NCAND); i++) begin
            if (w_cand_vld[i]) begin
                if (w_cand_preg[i] == '0) begin
                    w_gnt[i] = 1'b1;
                end else if (!w_p0_vld) begin
                    w_gnt[i]  = 1'b1;
                    w_p0_vld  = 1'b1;
                    w_p0_preg = w_cand_preg[i];
                    w_p0_data = w_cand_data[i];
                end else if (!w_p1_vld && (w_cand_preg[i] != w_p0_preg)) begin
                    w_gnt[i]  = 1'b1;
                    w_p1_vld  = 1'b1;
                    w_p1_preg = w_cand_preg[i];
                    w_p1_data = w_cand_data[i];
                end
            end
        end
    end

    assign w_lsu_gnt  = w_promote ? w_gnt[2] : w_gnt[1];
    assign w_mdu_gnt  = w_promote ? w_gnt[1] : w_gnt[2];
    assign lsu_wb_rdy = ~cpurst & ~rtu_yy_xx_flush & (~r_lsu_vld | w_lsu_gnt);
    assign mdu_wb_rdy = ~cpurst & ~rtu_yy_xx_flush & (~r_mdu_vld | w_mdu_gnt);
    assign w_lsu_acc  = lsu_wb_vld & lsu_wb_rdy;
    assign w_mdu_acc  = mdu_wb_vld & mdu_wb_rdy;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || rtu_yy_xx_flush) begin
            r_lsu_vld  <= 1'b0;
            r_lsu_preg <= '0;
            r_lsu_data <= '0;
        end else if (w_lsu_acc) begin
            r_lsu_vld  <= 1'b1;
            r_lsu_preg <= lsu_wb_preg;
            r_lsu_data <= lsu_wb_data;
        end else if (w_lsu_gnt) begin
            r_lsu_vld  <= 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || rtu_yy_xx_flush) begin
            r_mdu_vld  <= 1'b0;
            r_mdu_preg <= '0;
            r_mdu_data <= '0;
        end else if (w_mdu_acc) begin
            r_mdu_vld  <= 1'b1;
            r_mdu_preg <= mdu_wb_preg;
            r_mdu_data <= mdu_wb_data;
        end else if (w_mdu_gnt) begin
            r_mdu_vld  <= 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || rtu_yy_xx_flush) begin
            r_starve <= '0;
        end else if (!r_mdu_vld || w_mdu_gnt) begin
            r_starve <= '0;
        end else if (r_starve != LP_STARVE_MAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_wb0_vld  <= 1'b0;
            r_wb0_preg <= '0;
            r_wb0_data <= '0;
            r_wb1_vld  <= 1'b0;
            r_wb1_preg <= '0;
            r_wb1_data <= '0;
        end else begin
            r_wb0_vld  <= w_p0_vld;
            r_wb0_preg <= w_p0_preg;
            r_wb0_data <= w_p0_data;
            r_wb1_vld  <= w_p1_vld;
            r_wb1_preg <= w_p1_preg;
            r_wb1_data <= w_p1_data;
        end
    end

    assign rtu_idu_wb0_vld  = r_wb0_vld;
    assign rtu_idu_wb0_preg = r_wb0_preg;
    assign rtu_idu_wb0_data = r_wb0_data;
    assign rtu_idu_wb1_vld  = r_wb1_vld;
    assign rtu_idu_wb1_preg = r_wb1_preg;
    assign rtu_idu_wb1_data = r_wb1_data;

endmodule

// File: tb/tb_aq_rtu_gpr_wb_ctrl.sv
// Vector-table bench for aq_rtu_gpr_wb_ctrl: each row drives one cycle, checks rdy before
// the edge and the registered ports after it.
module tb_aq_rtu_gpr_wb_ctrl;

    logic        clk;
    logic        cpurst;
    logic        flush;
    logic        alu_vld;
    logic [5:0]  alu_preg;
    logic [63:0] alu_data;
    logic        lsu_vld;
    logic [5:0]  lsu_preg;
    logic [63:0] lsu_data;
    logic        lsu_rdy;
    logic        mdu_vld;
    logic [5:0]  mdu_preg;
    logic [63:0] mdu_data;
    logic        mdu_rdy;
    logic        wb0_vld;
    logic [5:0]  wb0_preg;
    logic [63:0] wb0_data;
    logic        wb1_vld;
    logic [5:0]  wb1_preg;
    logic [63:0] wb1_data;

    int n_checks;
    int n_errors;

    aq_rtu_gpr_wb_ctrl #(
        .PREG_W      (6),
        .DATA_W      (64),
        .STARVE_LIMIT(4)
    ) dut (
        .forever_cpuclk  (clk),
        .cpurst          (cpurst),
        .rtu_yy_xx_flush (flush),
        .alu_wb_vld      (alu_vld),
        .alu_wb_preg     (alu_preg),
        .alu_wb_data     (alu_data),
        .lsu_wb_vld      (lsu_vld),
        .lsu_wb_preg     (lsu_preg),
        .lsu_wb_data     (lsu_data),
        .lsu_wb_rdy      (lsu_rdy),
        .mdu_wb_vld      (mdu_vld),
        .mdu_wb_preg     (mdu_preg),
        .mdu_wb_data     (mdu_data),
        .mdu_wb_rdy      (mdu_rdy),
        .rtu_idu_wb0_vld (wb0_vld),
        .rtu_idu_wb0_preg(wb0_preg),
        .rtu_idu_wb0_data(wb0_data),
        .rtu_idu_wb1_vld (wb1_vld),
        .rtu_idu_wb1_preg(wb1_preg),
        .rtu_idu_wb1_data(wb1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        av;
        logic [5:0]  ap;
        logic [63:0] ad;
        logic        lv;
        logic [5:0]  lp;
        logic [63:0] ld;
        logic        mv;
        logic [5:0]  mp;
        logic [63:0] md;
        logic        lr;
        logic        mr;
        logic        w0v;
        logic [5:0]  w0p;
        logic [63:0] w0d;
        logic        w1v;
        logic [5:0]  w1p;
        logic [63:0] w1d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic fl,
        input logic av, input logic [5:0] ap, input logic [63:0] ad,
        input logic lv, input logic [5:0] lp, input logic [63:0] ld,
        input logic mv, input logic [5:0] mp, input logic [63:0] md,
        input logic lr, input logic mr,
        input logic w0v, input logic [5:0] w0p, input logic [63:0] w0d,
        input logic w1v, input logic [5:0] w1p, input logic [63:0] w1d);
        vec_t r;
        r.rst = rst; r.fl = fl;
        r.av = av; r.ap = ap; r.ad = ad;
        r.lv = lv; r.lp = lp; r.ld = ld;
        r.mv = mv; r.mp = mp; r.md = md;
        r.lr = lr; r.mr = mr;
        r.w0v = w0v; r.w0p = w0p; r.w0d = w0d;
        r.w1v = w1v; r.w1p = w1p; r.w1d = w1d;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic chk_inv(input int row);
        n_checks++;
        if (wb1_vld && (!wb0_vld || (wb0_preg == wb1_preg))) begin
            n_errors++;
            $display("FAIL port_invariant step %0d: wb0 %0b/%0d wb1 %0b/%0d", row,
                     wb0_vld, wb0_preg, wb1_vld, wb1_preg);
        end
    endtask

    task automatic drive(input vec_t x);
        cpurst   = x.rst;
        flush    = x.fl;
        alu_vld  = x.av;
        alu_preg = x.ap;
        alu_data = x.ad;
        lsu_vld  = x.lv;
        lsu_preg = x.lp;
        lsu_data = x.ld;
        mdu_vld  = x.mv;
        mdu_preg = x.mp;
        mdu_data = x.md;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cpurst   = 1'b1;
        flush    = 1'b0;
        alu_vld  = 1'b0; alu_preg = '0; alu_data = '0;
        lsu_vld  = 1'b0; lsu_preg = '0; lsu_data = '0;
        mdu_vld  = 1'b0; mdu_preg = '0; mdu_data = '0;

        //                 rst fl  alu          lsu             mdu            lr mr
        //                 wb0                wb1
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // three producers at once: ALU direct, LSU/MDU one cycle later on both ports
        vecs.push_back(v(0, 0, 1, 5, 'hA, 1, 6, 'hB, 1, 7, 'hC, 1, 1, 1, 5, 'hA, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 'hB, 1, 7, 'hC));
        // same preg in both buffers: serialised over two cycles
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 9, 'h11, 1, 9, 'h22, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 'h22, 0, 0, 0));
        // ALU preg 0 does not consume wb0
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 'h44, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 'h33, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // MDU starved by ALU+LSU for four cycles, then promoted
        vecs.push_back(v(0, 0, 1, 1, 'h1, 1, 10, 'h100, 1, 20, 'h200, 1, 1, 1, 1, 'h1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 2, 'h2, 1, 11, 'h101, 0, 0, 0, 1, 0, 1, 2, 'h2, 1, 10, 'h100));
        vecs.push_back(v(0, 0, 1, 3, 'h3, 1, 12, 'h102, 0, 0, 0, 1, 0, 1, 3, 'h3, 1, 11, 'h101));
        vecs.push_back(v(0, 0, 1, 4, 'h4, 1, 13, 'h103, 0, 0, 0, 1, 0, 1, 4, 'h4, 1, 12, 'h102));
        vecs.push_back(v(0, 0, 1, 5, 'h5, 1, 14, 'h104, 0, 0, 0, 1, 0, 1, 5, 'h5, 1, 13, 'h103));
        vecs.push_back(v(0, 0, 1, 6, 'h6, 1, 15, 'h105, 0, 0, 0, 0, 1, 1, 6, 'h6, 1, 20, 'h200));
        vecs.push_back(v(0, 0, 1, 7, 'h7, 1, 15, 'h105, 0, 0, 0, 1, 1, 1, 7, 'h7, 1, 14, 'h104));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 15, 'h105, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // flush with both buffers full, plus ALU and an LSU offer in the flush cycle
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 30, 'h300, 1, 31, 'h301, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 8, 'h8, 1, 32, 'h302, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // reset mid-stream discards buffered results
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 40, 'h400, 1, 41, 'h401, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 1, 9, 'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // ALU wins over both buffers holding its preg
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 50, 'h500, 1, 50, 'h501, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 50, 'h5A0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 50, 'h5A0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 50, 'h500, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 50, 'h501, 0, 0, 0));
        // LSU preg 0 skipped: MDU takes wb1
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 'h600, 1, 8, 'h601, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 7, 'h700, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 'h700, 1, 8, 'h601));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("lsu_rdy", i, 64'(lsu_rdy), 64'(vecs[i].lr));
            chk("mdu_rdy", i, 64'(mdu_rdy), 64'(vecs[i].mr));
            @(posedge clk);
            #1;
            chk("wb0_vld", i, 64'(wb0_vld), 64'(vecs[i].w0v));
            chk("wb1_vld", i, 64'(wb1_vld), 64'(vecs[i].w1v));
            if (vecs[i].w0v || vecs[i].rst) begin
                chk("wb0_preg", i, 64'(wb0_preg), 64'(vecs[i].w0p));
                chk("wb0_data", i, wb0_data, vecs[i].w0d);
            end
            if (vecs[i].w1v || vecs[i].rst) begin
                chk("wb1_preg", i, 64'(wb1_preg), 64'(vecs[i].w1p));
                chk("wb1_data", i, wb1_data, vecs[i].w1d);
            end
            chk_inv(i);
        end

        // back-to-back LSU stream: rdy stays high, each result lands two cycles later
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cpurst   = 1'b0;
            flush    = 1'b0;
            alu_vld  = 1'b0;
            mdu_vld  = 1'b0;
            lsu_vld  = (k < 6);
            lsu_preg = 6'(k + 1);
            lsu_data = 64'h1000 + 64'(k + 1);
            #1;
            chk("stream_lsu_rdy", 100 + k, 64'(lsu_rdy), 64'd1);
            @(posedge clk);
            #1;
            chk("stream_wb0_vld", 100 + k, 64'(wb0_vld), (k == 0) ? 64'd0 : 64'd1);
            if (k != 0) begin
                chk("stream_wb0_preg", 100 + k, 64'(wb0_preg), 64'(k));
                chk("stream_wb0_data", 100 + k, wb0_data, 64'h1000 + 64'(k));
            end
            chk("stream_wb1_vld", 100 + k, 64'(wb1_vld), 64'd0);
            chk_inv(100 + k);
        end

        @(negedge clk);
        lsu_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_drained", 107, 64'(wb0_vld), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
